ad_ip_jesd204_tpl_dac_start_seq: RTL and testbench

Start-up sequencer for the JESD204 DAC transport layer, running in the `link_clk` domain between the JESD link layer and the TPL DAC core. It waits for a stable `link_ready`, then waits for a software arm and an optional external trigger. It then issues a `dac_sync` pulse and opens the data gate toward the core. In RUN it counts DMA underflows and drops back to a safe state on link loss.

---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 14 +
 rtl/ad_ip_jesd204_tpl_dac_sync_edge.sv | 27 ++
 rtl/ad_ip_jesd204_tpl_dac_start_seq.sv | 141 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_start_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared state encoding for the JESD204 TPL DAC start-up sequencer.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_STABLE = 3'd1,
    ST_ARMED  = 3'd2,
    ST_SYNC   = 3'd3,
    ST_RUN    = 3'd4
  } dac_seq_state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module ad_ip_jesd204_tpl_dac_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
    end
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_start_seq.sv
// Start-up sequencer for the JESD204 TPL DAC: link-stable wait, arm, trigger, sync pulse, run.
// Optional external trigger path is built only when TPL_DAC_START_SEQ_EXT_SYNC_EN is defined.
module ad_ip_jesd204_tpl_dac_start_seq
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int unsigned READY_STABLE_CYCLES = 16,
  parameter int unsigned SYNC_PULSE_CYCLES   = 4,
  parameter int unsigned DUNF_CNT_WIDTH      = 16
) (
  input  logic                      link_clk,
  input  logic                      link_reset,
  input  logic                      link_ready,
  input  logic                      arm,
  input  logic                      ext_sync_in,
  input  logic                      ext_sync_en,
  input  logic                      dac_dunf,
  input  logic                      status_clr,
  output logic                      dac_sync,
  output logic                      data_enable,
  output logic                      armed,
  output logic                      link_lost,
  output logic [DUNF_CNT_WIDTH-1:0] dunf_count,
  output logic [STATE_W-1:0]        state
);

  localparam logic [7:0] STABLE_LIM = 8'(READY_STABLE_CYCLES);
  localparam logic [3:0] PULSE_LIM  = 4'(SYNC_PULSE_CYCLES);

  dac_seq_state_t state_q;
  dac_seq_state_t state_nxt;
  logic [7:0]     stab_q;
  logic [7:0]     stab_nxt;
  logic [3:0]     pulse_q;
  logic [3:0]     pulse_nxt;
  logic           lost_set;
  logic           trig;

`ifdef TPL_DAC_START_SEQ_EXT_SYNC_EN
  logic ext_rise;

  ad_ip_jesd204_tpl_dac_sync_edge u_sync_edge (
    .clk  (link_clk),
    .rst  (link_reset),
    .din  (ext_sync_in),
    .rise (ext_rise)
  );

  assign trig = ~ext_sync_en | ext_rise;
`else
  logic unused_ext;

  assign unused_ext = ext_sync_in ^ ext_sync_en;
  assign trig       = 1'b1;
`endif

  // Branch order encodes priority: link loss, then disarm, then trigger.
  always_comb begin
    state_nxt = state_q;
    stab_nxt  = stab_q;
    pulse_nxt = pulse_q;
    lost_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (link_ready) begin
          state_nxt = ST_STABLE;
          stab_nxt  = 8'd1;
        end
      end
      ST_STABLE: begin
        if (!link_ready) begin
          state_nxt = ST_IDLE;
        end else if (stab_q >= STABLE_LIM) begin
          if (arm) state_nxt = ST_ARMED;
        end else begin
          stab_nxt = stab_q + 8'd1;
        end
      end
      ST_ARMED: begin
        if (!link_ready || !arm) begin
          state_nxt = ST_IDLE;
        end else if (trig) begin
          state_nxt = ST_SYNC;
          pulse_nxt = 4'd1;
        end
      end
      ST_SYNC: begin
        if (!link_ready) begin
          state_nxt = ST_IDLE;
          lost_set  = 1'b1;
        end else if (pulse_q >= PULSE_LIM) begin
          state_nxt = ST_RUN;
        end else begin
          pulse_nxt = pulse_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (!link_ready) begin
          state_nxt = ST_IDLE;
          lost_set  = 1'b1;
        end else if (!arm) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they switch together with the state register.
  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      state_q     <= ST_IDLE;
      stab_q      <= '0;
      pulse_q     <= '0;
      dac_sync    <= 1'b0;
      data_enable <= 1'b0;
      armed       <= 1'b0;
      link_lost   <= 1'b0;
      dunf_count  <= '0;
    end else begin
      state_q     <= state_nxt;
      stab_q      <= stab_nxt;
      pulse_q     <= pulse_nxt;
      dac_sync    <= (state_nxt == ST_SYNC);
      data_enable <= (state_nxt == ST_RUN);
      armed       <= (state_nxt == ST_ARMED);
      if (status_clr) begin
        link_lost <= 1'b0;
      end else if (lost_set) begin
        link_lost <= 1'b1;
      end
      if (status_clr) begin
        dunf_count <= '0;
      end else if (dac_dunf && (state_q == ST_RUN) && (dunf_count != '1)) begin
        dunf_count <= dunf_count + DUNF_CNT_WIDTH'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_start_seq.sv
// Self-checking bench for ad_ip_jesd204_tpl_dac_start_seq: directed start-up scenarios plus random stimulus
// compared every cycle against a behavioural model.
module tb_ad_ip_jesd204_tpl_dac_start_seq;

  localparam int RS   = 16;
  localparam int SP   = 4;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_STABLE = 1;
  localparam int M_ARMED  = 2;
  localparam int M_SYNC   = 3;
  localparam int M_RUN    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          lr, arm, esi, ese, dunf, clr;
  logic          dac_sync, data_enable, armed, link_lost;
  logic [DW-1:0] dunf_count;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int m_state, m_stab, m_pulse, m_dunf;
  bit m_lost;
`ifdef TPL_DAC_START_SEQ_EXT_SYNC_EN
  bit [3:0] m_hist;
`endif

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_start_seq #(
    .READY_STABLE_CYCLES (RS),
    .SYNC_PULSE_CYCLES   (SP),
    .DUNF_CNT_WIDTH      (DW)
  ) dut (
    .link_clk    (clk),
    .link_reset  (rst),
    .link_ready  (lr),
    .arm         (arm),
    .ext_sync_in (esi),
    .ext_sync_en (ese),
    .dac_dunf    (dunf),
    .status_clr  (clr),
    .dac_sync    (dac_sync),
    .data_enable (data_enable),
    .armed       (armed),
    .link_lost   (link_lost),
    .dunf_count  (dunf_count),
    .state       (state)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_stab  = 0;
    m_pulse = 0;
    m_dunf  = 0;
    m_lost  = 1'b0;
`ifdef TPL_DAC_START_SEQ_EXT_SYNC_EN
    m_hist  = '0;
`endif
  endtask

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_step();
    int prev;
    bit trig;
    bit lost_evt;
    prev     = m_state;
    lost_evt = 1'b0;
    trig     = 1'b1;
`ifdef TPL_DAC_START_SEQ_EXT_SYNC_EN
    // a rise sampled at edge k is usable as a trigger at edge k+3
    trig   = !ese || (m_hist[2] && !m_hist[3]);
    m_hist = {m_hist[2:0], esi};
`endif
    case (prev)
      M_IDLE: if (lr) begin m_state = M_STABLE; m_stab = 1; end
      M_STABLE: begin
        if (!lr) m_state = M_IDLE;
        else if (m_stab == RS) begin if (arm) m_state = M_ARMED; end
        else m_stab++;
      end
      M_ARMED: begin
        if (!lr || !arm) m_state = M_IDLE;
        else if (trig) begin m_state = M_SYNC; m_pulse = 1; end
      end
      M_SYNC: begin
        if (!lr) begin m_state = M_IDLE; lost_evt = 1'b1; end
        else if (m_pulse == SP) m_state = M_RUN;
        else m_pulse++;
      end
      M_RUN: begin
        if (!lr) begin m_state = M_IDLE; lost_evt = 1'b1; end
        else if (!arm) m_state = M_IDLE;
      end
      default: m_state = M_IDLE;
    endcase
    if (clr) m_lost = 1'b0;
    else if (lost_evt) m_lost = 1'b1;
    if (clr) m_dunf = 0;
    else if (dunf && prev == M_RUN && m_dunf < DMAX) m_dunf++;
  endtask

  task automatic check_all();
    chk("state", int'(state), m_state);
    chk("armed", int'(armed), int'(m_state == M_ARMED));
    chk("dac_sync", int'(dac_sync), int'(m_state == M_SYNC));
    chk("data_enable", int'(data_enable), int'(m_state == M_RUN));
    chk("link_lost", int'(link_lost), int'(m_lost));
    chk("dunf_count", int'(dunf_count), m_dunf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string nm);
    #2;
    rst = 1'b1;
    #1;
    chk({nm, "_async_state"}, int'(state), 0);
    chk({nm, "_async_dac_sync"}, int'(dac_sync), 0);
    chk({nm, "_async_data_enable"}, int'(data_enable), 0);
    chk({nm, "_async_armed"}, int'(armed), 0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
    rst = 1'b0;
  endtask

  task automatic wait_state(input string nm, input int st, input int bound);
    int n;
    n = 0;
    while (m_state != st && n < bound) begin
      tick();
      n++;
    end
    chk({nm, "_reached"}, int'(state), st);
  endtask

  initial begin
    int r;
    int plr;
    rst = 1'b1; lr = 1'b0; arm = 1'b0; esi = 1'b0; ese = 1'b0; dunf = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_state_lit", int'(state), 0);
    rst = 1'b0;
    cyc = 0;

    // Nominal start: link_ready first sampled at edge 10.
    arm = 1'b1;
    while (cyc < 9) tick();
    lr = 1'b1;
    while (cyc < 32) begin
      tick();
      if (cyc == 25) chk("nom_stable25", int'(state), 1);
      if (cyc == 26) begin chk("nom_armed26", int'(armed), 1); chk("nom_state26", int'(state), 2); end
      if (cyc == 27) begin chk("nom_sync27", int'(dac_sync), 1); chk("nom_armed27", int'(armed), 0); end
      if (cyc == 30) chk("nom_sync30", int'(dac_sync), 1);
      if (cyc == 31) begin
        chk("nom_sync31", int'(dac_sync), 0);
        chk("nom_de31", int'(data_enable), 1);
        chk("nom_state31", int'(state), 4);
      end
    end

    // Link loss in RUN, then clear.
    lr = 1'b0;
    tick();
    chk("loss_state", int'(state), 0);
    chk("loss_de", int'(data_enable), 0);
    chk("loss_flag", int'(link_lost), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("loss_clr", int'(link_lost), 0);

    // Glitchy link: 10 high, 1 low, then the stable count restarts.
    lr = 1'b1;
    repeat (10) tick();
    lr = 1'b0;
    tick();
    chk("glitch_idle", int'(state), 0);
    lr = 1'b1;
    r = cyc + 1;
    repeat (16) tick();
    chk("glitch_stable_r15", cyc - r, 15);
    chk("glitch_not_armed", int'(armed), 0);
    tick();
    chk("glitch_armed_r16", int'(armed), 1);

    // Underflow saturation with a 4-bit counter.
    repeat (5) tick();
    chk("dunf_in_run", int'(state), 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dunf = 1'b1;
    repeat (20) tick();
    chk("dunf_sat", int'(dunf_count), 15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("dunf_clr_wins", int'(dunf_count), 0);
    dunf = 1'b0;
    arm = 1'b0;
    tick();
    chk("disarm_idle", int'(state), 0);
    dunf = 1'b1;
    repeat (5) tick();
    chk("dunf_idle_nocount", int'(dunf_count), 0);
    dunf = 1'b0;

    // Async reset in the middle of SYNC.
    arm = 1'b1;
    wait_state("to_sync", M_SYNC, 40);
    chk("presync_pulse", int'(dac_sync), 1);
    async_reset("sync");

`ifdef TPL_DAC_START_SEQ_EXT_SYNC_EN
    // External trigger: an early edge is dropped, an edge inside ARMED fires 3 edges later.
    ese = 1'b1;
    lr  = 1'b1;
    arm = 1'b1;
    repeat (2) tick();
    esi = 1'b1;
    repeat (2) tick();
    esi = 1'b0;
    wait_state("ext_armed", M_ARMED, 40);
    repeat (5) tick();
    chk("ext_early_dropped", int'(state), 2);
    esi = 1'b1;
    r = cyc + 1;
    repeat (3) tick();
    chk("ext_wait_e2", int'(state), 2);
    tick();
    chk("ext_sync_e3", int'(state), 3);
    chk("ext_sync_e3_idx", cyc - r, 3);
    esi = 1'b0;
`endif

    // Random phase in segments with varying link quality.
    for (int seg = 0; seg < 8; seg++) begin
      plr = (seg % 2 == 0) ? 99 : 93;
      ese = 1'(seg % 3 == 1);
      for (int i = 0; i < 350; i++) begin
        lr   = 1'($urandom_range(99) < plr);
        arm  = 1'($urandom_range(99) < 97);
        dunf = 1'($urandom_range(99) < 30);
        clr  = 1'($urandom_range(99) < 3);
        if ($urandom_range(99) < 15) esi = ~esi;
        if ($urandom_range(999) < 3) begin
          async_reset("rand");
        end else begin
          tick();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
